// File: rtl/clk_div_monitor_if.sv
// Bundle of control inputs and measurement outputs for the divided-clock monitor.
// The bench or the surrounding logic drives the master side; the monitor is the slave side.
interface clk_div_monitor_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic             div_in;
    logic             clr_err;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_vld;
    logic             locked;
    logic             err;
    logic [7:0]       err_cnt;

    modport master (
        output enable, div_in, clr_err,
        input  period, high_time, period_vld, locked, err, err_cnt
    );

    modport slave (
        input  enable, div_in, clr_err,
        output period, high_time, period_vld, locked, err, err_cnt
    );
endinterface

// File: rtl/clk_div_monitor.sv
// Receive-side checker for a clk-synchronous divided clock.
// Finds rising edges of div_in, measures period and high time between edges,
// declares lock after LOCK_CNT consecutive periods of exactly DIV_N cycles,
// and flags ratio errors or stalls (no edge within 2*DIV_N cycles) while locked.
module clk_div_monitor #(
    parameter int DIV_N    = 5,
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    clk_div_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACQUIRE,
        S_MEASURE,
        S_LOCKED
    } state_t;

    localparam int               GW          = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] C_PERIOD    = CNT_W'(DIV_N);
    localparam logic [CNT_W-1:0] C_STALL     = CNT_W'(2 * DIV_N);
    localparam logic [GW-1:0]    C_LOCK_LAST = GW'(LOCK_CNT - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_div_q;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hcnt;
    logic [GW-1:0]    r_good_cnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high_time;
    logic             r_period_vld;
    logic             r_locked;
    logic             r_err;
    logic [7:0]       r_err_cnt;

    logic             w_rise;
    logic             w_tracking;
    logic             w_good;
    logic             w_stall;
    logic             w_vld_nxt;
    logic             w_lock_hit;
    logic             w_err_nxt;

    assign w_rise = bus.div_in && !r_div_q;

    // State register: holds the acquisition/lock state of the monitor.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: enable low forces IDLE from anywhere.
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        if (!bus.enable) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    w_next_state = S_ACQUIRE;
                S_ACQUIRE: if (w_rise) w_next_state = S_MEASURE;
                S_MEASURE: begin
                    if (w_stall)         w_next_state = S_ACQUIRE;
                    else if (w_lock_hit) w_next_state = S_LOCKED;
                end
                S_LOCKED: begin
                    if (w_stall)                  w_next_state = S_ACQUIRE;
                    else if (w_rise && !w_good)   w_next_state = S_MEASURE;
                end
                default:   w_next_state = S_IDLE;
            endcase
        end
    end

    // Output decode: which pulses and status changes the current cycle produces.
    always_comb begin
        w_tracking = bus.enable && ((r_state == S_MEASURE) || (r_state == S_LOCKED));
        w_good     = (r_cnt == C_PERIOD);
        w_stall    = w_tracking && !w_rise && (r_cnt == C_STALL);
        w_vld_nxt  = w_tracking && w_rise;
        w_lock_hit = w_vld_nxt && (r_state == S_MEASURE) && w_good && (r_good_cnt == C_LOCK_LAST);
        w_err_nxt  = (r_state == S_LOCKED) && ((w_vld_nxt && !w_good) || w_stall);
    end

    // Edge sampler plus period, high-time and good-period counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_q    <= 1'b0;
            r_cnt      <= '0;
            r_hcnt     <= '0;
            r_good_cnt <= '0;
        end else begin
            r_div_q <= bus.div_in;
            if (!bus.enable || (r_state == S_IDLE)) begin
                r_cnt      <= '0;
                r_hcnt     <= '0;
                r_good_cnt <= '0;
            end else if (r_state == S_ACQUIRE) begin
                r_cnt      <= w_rise ? CNT_W'(1) : '0;
                r_hcnt     <= w_rise ? CNT_W'(1) : '0;
                r_good_cnt <= '0;
            end else if (w_stall) begin
                r_cnt      <= '0;
                r_hcnt     <= '0;
                r_good_cnt <= '0;
            end else if (w_rise) begin
                // The rise cycle is itself high, so both counts restart at 1.
                r_cnt  <= CNT_W'(1);
                r_hcnt <= CNT_W'(1);
                if (!w_good)                     r_good_cnt <= '0;
                else if (r_state == S_MEASURE)   r_good_cnt <= r_good_cnt + GW'(1);
            end else begin
                r_cnt  <= r_cnt + CNT_W'(r_cnt != '1);
                r_hcnt <= r_hcnt + CNT_W'(bus.div_in && (r_hcnt != '1));
            end
        end
    end

    // Registered measurement outputs, status and single-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period     <= '0;
            r_high_time  <= '0;
            r_period_vld <= 1'b0;
            r_locked     <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_vld_nxt) begin
                r_period    <= r_cnt;
                r_high_time <= r_hcnt;
            end
            r_period_vld <= w_vld_nxt;
            r_locked     <= (w_next_state == S_LOCKED);
            r_err        <= w_err_nxt;
        end
    end

    // Saturating error counter; a clear coinciding with an error leaves one error counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (bus.clr_err) begin
            r_err_cnt <= {7'd0, w_err_nxt};
        end else if (w_err_nxt && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign bus.period     = r_period;
    assign bus.high_time  = r_high_time;
    assign bus.period_vld = r_period_vld;
    assign bus.locked     = r_locked;
    assign bus.err        = r_err;
    assign bus.err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a queue-based reference model.
module tb_clk_div_monitor;

    localparam int DIV_N    = 5;
    localparam int CNT_W    = 8;
    localparam int LOCK_CNT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    clk_div_monitor_if #(.CNT_W(CNT_W)) bus ();

    clk_div_monitor #(
        .DIV_N   (DIV_N),
        .CNT_W   (CNT_W),
        .LOCK_CNT(LOCK_CNT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 waiting for a first edge, 2 timing periods.
    // The samples seen since the last rising edge are kept in a queue; its length is
    // the elapsed period and its ones are the high time.
    bit               m_prev;
    int               m_mode;
    bit               m_locked;
    int               m_streak;
    bit               q_hist[$];
    logic [CNT_W-1:0] e_period;
    logic [CNT_W-1:0] e_high;
    bit               e_vld;
    bit               e_err;
    int               e_errcnt;

    // Observation of DUT pulses for the directed literal checks.
    int  cyc          = 0;
    int  n_vld        = 0;
    int  n_err        = 0;
    int  n_offnom     = 0;
    int  lock_vld_num = 0;
    int  last_vld_cyc = 0;
    int  last_err_cyc = 0;
    bit  prev_lk      = 1'b0;

    always @(posedge clk) begin
        bit rise;
        bit err_ev;
        int hi;
        if (!rst_n) begin
            m_prev = 0; m_mode = 0; m_locked = 0; m_streak = 0;
            q_hist.delete();
            e_period = '0; e_high = '0; e_vld = 0; e_err = 0; e_errcnt = 0;
        end else begin
            rise   = bus.div_in && !m_prev;
            err_ev = 0;
            e_vld  = 0;
            if (!bus.enable) begin
                m_mode = 0; m_locked = 0; m_streak = 0;
                q_hist.delete();
            end else if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (rise) begin
                    m_mode = 2;
                    q_hist.delete();
                    q_hist.push_back(1'b1);
                end
            end else if (rise) begin
                hi = 0;
                foreach (q_hist[i]) hi += int'(q_hist[i]);
                e_vld    = 1;
                e_period = CNT_W'(q_hist.size());
                e_high   = CNT_W'(hi);
                if (q_hist.size() == DIV_N) begin
                    m_streak++;
                    if (!m_locked && m_streak == LOCK_CNT) m_locked = 1;
                end else begin
                    err_ev   = m_locked;
                    m_locked = 0;
                    m_streak = 0;
                end
                q_hist.delete();
                q_hist.push_back(1'b1);
            end else if (q_hist.size() == 2 * DIV_N) begin
                err_ev   = m_locked;
                m_locked = 0;
                m_streak = 0;
                m_mode   = 1;
                q_hist.delete();
            end else begin
                q_hist.push_back(bus.div_in);
            end
            e_err = err_ev;
            if (bus.clr_err)       e_errcnt = err_ev ? 1 : 0;
            else if (err_ev)       e_errcnt = (e_errcnt < 255) ? e_errcnt + 1 : 255;
            m_prev = bus.div_in;
        end
        #1;
        if (rst_n) begin
            check("period",     bus.period,     e_period);
            check("high_time",  bus.high_time,  e_high);
            check("period_vld", bus.period_vld, e_vld);
            check("locked",     bus.locked,     m_locked);
            check("err",        bus.err,        e_err);
            check("err_cnt",    bus.err_cnt,    e_errcnt);
            cyc++;
            if (bus.period_vld) begin
                n_vld++;
                last_vld_cyc = cyc;
                if (bus.period != 5 || bus.high_time != 2) n_offnom++;
                if (bus.locked && !prev_lk) lock_vld_num = n_vld;
            end
            if (bus.err) begin
                n_err++;
                last_err_cyc = cyc;
            end
            prev_lk = bus.locked;
        end
    end

    task automatic drive(input logic d, input logic e, input logic c);
        @(negedge clk);
        bus.div_in  = d;
        bus.enable  = e;
        bus.clr_err = c;
    endtask

    // One divider period: low cycles first, then 'high' cycles high.
    task automatic send_period(input int len, input int high, input logic clr_at_rise = 1'b0);
        for (int i = 0; i < len; i++)
            drive(logic'(i >= len - high), 1'b1, clr_at_rise && (i == len - high));
    endtask

    int base_v, base_e, base_off, lv;

    initial begin
        bus.div_in  = 1'b0;
        bus.enable  = 1'b0;
        bus.clr_err = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0);
        drive(0, 0, 0);

        // Nominal 0,0,0,1,1 pattern: first edge only acquires, lock on 4th period_vld.
        base_v = n_vld; base_e = n_err; base_off = n_offnom;
        repeat (5) send_period(5, 2);
        check("t2_vld_count",  n_vld - base_v, 4);
        check("t2_lock_vld",   lock_vld_num - base_v, 4);
        check("t2_off_nominal", n_offnom - base_off, 0);
        check("t2_period",     bus.period, 5);
        check("t2_high_time",  bus.high_time, 2);
        check("t2_locked",     bus.locked, 1);
        check("t2_no_err",     n_err - base_e, 0);

        // Single 4-cycle period after lock.
        base_e = n_err;
        send_period(4, 2);
        check("t3_err_pulses", n_err - base_e, 1);
        check("t3_err_cnt",    bus.err_cnt, 1);
        check("t3_unlocked",   bus.locked, 0);
        check("t3_period",     bus.period, 4);
        repeat (3) send_period(5, 2);
        check("t3_not_yet",    bus.locked, 0);
        send_period(5, 2);
        check("t3_relocked",   bus.locked, 1);

        // Stall while locked.
        base_v = n_vld; base_e = n_err; lv = last_vld_cyc;
        repeat (14) drive(0, 1, 0);
        check("t4_err_delay",  last_err_cyc - lv, 10);
        check("t4_err_pulses", n_err - base_e, 1);
        check("t4_no_vld",     n_vld - base_v, 0);
        check("t4_unlocked",   bus.locked, 0);
        check("t4_err_cnt",    bus.err_cnt, 2);
        send_period(5, 2);
        send_period(5, 2);
        check("t4_acquire",    n_vld - base_v, 1);

        // Disable mid-period.
        repeat (3) send_period(5, 2);
        check("t5_locked_before", bus.locked, 1);
        base_v = n_vld; base_e = n_err;
        drive(0, 1, 0); drive(0, 1, 0);
        drive(0, 0, 0); drive(1, 0, 0); drive(1, 0, 0); drive(0, 0, 0);
        check("t5_no_vld",     n_vld - base_v, 0);
        check("t5_no_err",     n_err - base_e, 0);
        check("t5_unlocked",   bus.locked, 0);
        check("t5_err_cnt",    bus.err_cnt, 2);
        repeat (4) send_period(5, 2);
        check("t5_not_yet",    bus.locked, 0);
        send_period(5, 2);
        check("t5_relocked",   bus.locked, 1);

        // Clear together with an error, then saturation.
        base_e = n_err;
        send_period(4, 2, 1'b1);
        check("t6_clr_with_err", bus.err_cnt, 1);
        check("t6_err_pulse",    n_err - base_e, 1);
        base_e = n_err;
        repeat (300) begin
            repeat (4) send_period(5, 2);
            send_period(4, 2);
        end
        check("t6_forced_errs", n_err - base_e, 300);
        check("t6_saturated",   bus.err_cnt, 255);
        drive(0, 1, 1);
        drive(0, 1, 0);
        check("t6_clr_alone",   bus.err_cnt, 0);

        // Build a locked state with a nonzero err_cnt, then reset mid-period.
        repeat (5) send_period(5, 2);
        send_period(4, 2);
        repeat (4) send_period(5, 2);
        check("t1_locked_before",  bus.locked, 1);
        check("t1_errcnt_before",  bus.err_cnt, 1);
        drive(0, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t1_period",     bus.period, 0);
        check("t1_high_time",  bus.high_time, 0);
        check("t1_period_vld", bus.period_vld, 0);
        check("t1_locked",     bus.locked, 0);
        check("t1_err",        bus.err, 0);
        check("t1_err_cnt",    bus.err_cnt, 0);
        drive(0, 0, 0);
        drive(0, 0, 0);
        rst_n = 1'b1;
        base_v = n_vld;
        drive(0, 0, 0); drive(1, 0, 0); drive(0, 0, 0); drive(1, 0, 0); drive(0, 0, 0);
        check("t1_idle_no_vld", n_vld - base_v, 0);
        check("t1_idle_locked", bus.locked, 0);

        // Randomized traffic, checked every cycle against the model.
        repeat (400) begin
            int r;
            int len;
            r = int'($urandom_range(0, 99));
            if (r < 5) begin
                repeat ($urandom_range(9, 14)) drive(0, 1, 0);
            end else if (r < 8) begin
                repeat ($urandom_range(1, 4)) drive(logic'($urandom_range(0, 1)), 0, 0);
            end else if (r < 70) begin
                send_period(5, 2, logic'(r % 17 == 0));
            end else begin
                len = int'($urandom_range(2, 8));
                send_period(len, int'($urandom_range(1, len - 1)), logic'(r % 13 == 0));
            end
        end
        drive(0, 0, 0);
        drive(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
